// File: rtl/hb_dec_mc.sv
// Multi-channel half-band decimate-by-2 filter, fixed 7-tap kernel
//   y = sat((-x0 + 9x2 + 16x3 + 9x4 - x6 + 16) >>> 5)
// All channels share one strobe, one phase bit and one set of pipeline valids.
// The newest sample x[n] is taken straight from data_in; six registers hold
// x[n-1]..x[n-6]. Multiplies are shift-add only.
module hb_dec_mc #(
  parameter int WIDTH = 18,
  parameter int NCHAN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   bypass,
  input  logic                   stb_in,
  input  logic [NCHAN*WIDTH-1:0] data_in,
  output logic                   stb_out,
  output logic [NCHAN*WIDTH-1:0] data_out
);

  localparam int ACC_W = WIDTH + 6;
  localparam logic signed [ACC_W-1:0] RND = 16;

  // Add half an LSB, drop 5 fraction bits, clamp to the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] rnd_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    logic signed [WIDTH:0]   q;
    s = acc + RND;
    q = s[ACC_W-1:5];
    if (q[WIDTH] != q[WIDTH-1])
      rnd_sat = q[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      rnd_sat = q[WIDTH-1:0];
  endfunction

  logic bypass_r;
  logic flush_pend;
  logic phase;
  logic vld_p0;
  logic vld_p1;
  logic flush;
  logic accept;
  logic load_out;

  // A bypass edge seen on the registered copy flushes one cycle later.
  assign flush    = clear | flush_pend;
  assign accept   = stb_in & ~bypass & ~flush;
  assign load_out = bypass ? stb_in : (vld_p1 & ~flush);

  // Control: bypass edge detect, decimation phase, pipeline valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_r   <= 1'b0;
      flush_pend <= 1'b0;
      phase      <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      bypass_r   <= bypass;
      flush_pend <= bypass ^ bypass_r;
      if (flush) begin
        phase  <= 1'b0;
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
      end else begin
        if (accept) phase <= ~phase;
        vld_p0 <= accept & phase;
        vld_p1 <= vld_p0;
      end
    end
  end

  // Output strobe: bypass passes the input strobe, filter mode the stage-2 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stb_out <= 1'b0;
    else        stb_out <= load_out;
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_ch
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] dl [6];
    logic signed [WIDTH:0]   mid_p0;
    logic signed [WIDTH:0]   out_p0;
    logic signed [WIDTH-1:0] ctr_p0;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [WIDTH-1:0] y_p2;
    logic signed [ACC_W-1:0] mid_x;
    logic signed [ACC_W-1:0] out_x;
    logic signed [ACC_W-1:0] ctr_x;

    assign x_in  = data_in[k*WIDTH +: WIDTH];
    assign mid_x = {{(ACC_W-WIDTH-1){mid_p0[WIDTH]}}, mid_p0};
    assign out_x = {{(ACC_W-WIDTH-1){out_p0[WIDTH]}}, out_p0};
    assign ctr_x = {{(ACC_W-WIDTH){ctr_p0[WIDTH-1]}}, ctr_p0};
    assign data_out[k*WIDTH +: WIDTH] = y_p2;

    // Delay line x[n-1]..x[n-6]: shifts on each accepted sample, zeroed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 6; i++) dl[i] <= '0;
      end else if (flush) begin
        for (int i = 0; i < 6; i++) dl[i] <= '0;
      end else if (accept) begin
        dl[0] <= x_in;
        for (int i = 1; i < 6; i++) dl[i] <= dl[i-1];
      end
    end

    // Stage 0: pre-add symmetric pairs x2+x4 and x0+x6, carry centre tap x3.
    always_ff @(posedge clk) begin
      mid_p0 <= {dl[1][WIDTH-1], dl[1]} + {dl[3][WIDTH-1], dl[3]};
      out_p0 <= {x_in[WIDTH-1], x_in} + {dl[5][WIDTH-1], dl[5]};
      ctr_p0 <= dl[2];
    end

    // Stage 1: 9*mid + 16*ctr - out as shift-add.
    always_ff @(posedge clk) begin
      acc_p1 <= (mid_x <<< 3) + mid_x + (ctr_x <<< 4) - out_x;
    end

    // Stage 2: output register, holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        y_p2 <= '0;
      else if (load_out) y_p2 <= bypass ? x_in : rnd_sat(acc_p1);
    end
  end

endmodule

// File: tb/tb_hb_dec_mc.sv
// Scoreboard bench for hb_dec_mc (WIDTH=18, NCHAN=2). Stimulus tasks push the
// expected output and its arrival cycle; an independent monitor pops on stb_out.
module tb_hb_dec_mc;
  localparam int W  = 18;
  localparam int NC = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            bypass = 1'b0;
  logic            stb_in = 1'b0;
  logic [NC*W-1:0] data_in = '0;
  logic            stb_out;
  logic [NC*W-1:0] data_out;

  hb_dec_mc #(.WIDTH(W), .NCHAN(NC)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bypass(bypass),
    .stb_in(stb_in), .data_in(data_in), .stb_out(stb_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int a; int b; int c; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int hist[2][7];
  bit ph;

  int dc0[6] = '{-31, 750, 1031, 1000, 1000, 1000};
  int dc1[6] = '{31, -750, -1031, -1000, -1000, -1000};
  int s0[8]  = '{0, -131072, 0, 131071, 131071, 131071, 0, -131072};
  int s1[8]  = '{0, 131071, 0, -131072, -131072, -131072, 0, 131071};
  int se0[4] = '{4096, -40960, -4096, 131071};
  int se1[4] = '{-4096, 40960, 4096, -131072};
  int r0[24];
  int r1[24];

  function automatic int ch(input int k);
    logic signed [W-1:0] v;
    v = data_out[k*W +: W];
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ymodel(input int c);
    int acc;
    acc = -hist[c][0] + 9*hist[c][2] + 16*hist[c][3] + 9*hist[c][4] - hist[c][6] + 16;
    acc = acc >>> 5;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
    return acc;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 7; i++) hist[c][i] = 0;
    ph = 1'b0;
  endtask

  task automatic drop_after(input int c);
    while (q.size() > 0 && q[q.size()-1].c > c) q.delete(q.size()-1);
  endtask

  // One sample in one cycle; hand-computed expectations override the model.
  task automatic send(input int a, input int b, input bit hand = 1'b0,
                      input int ea = 0, input int eb = 0);
    exp_t e;
    @(negedge clk);
    clear   = 1'b0;
    stb_in  = 1'b1;
    data_in = {b[W-1:0], a[W-1:0]};
    if (bypass) begin
      e.a = a; e.b = b; e.c = cyc + 1;
      q.push_back(e);
    end else begin
      for (int i = 6; i > 0; i--) begin
        hist[0][i] = hist[0][i-1];
        hist[1][i] = hist[1][i-1];
      end
      hist[0][0] = a;
      hist[1][0] = b;
      if (ph) begin
        e.a = hand ? ea : ymodel(0);
        e.b = hand ? eb : ymodel(1);
        e.c = cyc + 3;
        q.push_back(e);
      end
      ph = ~ph;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear   = 1'b0;
      stb_in  = 1'b0;
      data_in = 36'({$urandom(), $urandom()});
      @(posedge clk);
    end
  endtask

  task automatic do_clear(input bit junk);
    @(negedge clk);
    clear   = 1'b1;
    stb_in  = junk;
    data_in = 36'h1_2345_6789;
    drop_after(cyc);
    model_reset();
    @(posedge clk);
  endtask

  task automatic set_bypass(input bit v, input bit junk);
    @(negedge clk);
    clear   = 1'b0;
    bypass  = v;
    stb_in  = junk;
    data_in = {18'sd5000, 18'sd5000};
    drop_after(cyc);
    @(posedge clk);
    @(negedge clk);
    stb_in  = junk;
    @(posedge clk);
    model_reset();
  endtask

  // Impulse 32 on ch0 at n=1, on ch1 at n=0.
  task automatic impulse_run();
    send(0, 32);
    send(32, 0, 1'b1, -1, 0);
    send(0, 0);
    send(0, 0, 1'b1, 9, 16);
    send(0, 0);
    send(0, 0, 1'b1, 9, 0);
    send(0, 0);
    send(0, 0, 1'b1, -1, 0);
    send(0, 0);
    send(0, 0, 1'b1, 0, 0);
  endtask

  // Monitor: compare every output pulse against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (stb_out) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_out cyc=%0d got %0d,%0d required no output", cyc, ch(0), ch(1));
        end else begin
          mon_e = q.pop_front();
          check("out_ch0", ch(0), mon_e.a);
          check("out_ch1", ch(1), mon_e.b);
          check("out_cycle", cyc, mon_e.c);
        end
      end else if (q.size() > 0 && q[0].c < cyc) begin
        total++; bad++;
        $display("FAIL missing_out cyc=%0d got none required %0d,%0d at cyc %0d",
                 cyc, q[0].a, q[0].b, q[0].c);
        q.delete(0);
      end
    end
  end

  initial begin
    int t;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      r0[i] = int'($urandom_range(0, 262143)) - 131072;
      r1[i] = int'($urandom_range(0, 262143)) - 131072;
    end

    #2;
    check("rst_stb", int'(stb_out), 0);
    check("rst_data0", ch(0), 0);
    check("rst_data1", ch(1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    impulse_run();
    idle(6);
    do_clear(1'b1);

    for (int i = 0; i < 12; i++) send(1000, -1000, 1'b1, dc0[i/2], dc1[i/2]);
    idle(6);
    do_clear(1'b0);

    for (int i = 0; i < 8; i++) send(s0[i], s1[i], 1'b1, se0[i/2], se1[i/2]);
    idle(6);
    do_clear(1'b1);

    for (int i = 0; i < 24; i++) send(r0[i], r1[i]);
    idle(6);
    do_clear(1'b0);
    for (int i = 0; i < 24; i++) begin
      send(r0[i], r1[i]);
      idle(2);
    end
    idle(6);

    set_bypass(1'b1, 1'b0);
    send(5, -131072);
    send(-7, 0);
    send(131071, 1);
    idle(3);
    set_bypass(1'b0, 1'b1);
    impulse_run();
    idle(6);

    // Asynchronous reset between edges right after an output pulse.
    send(0, 32);
    send(32, 0, 1'b1, -1, 0);
    send(0, 0);
    send(0, 0, 1'b1, 9, 16);
    #3;
    rst_n  = 1'b0;
    stb_in = 1'b0;
    #1;
    check("async_rst_stb", int'(stb_out), 0);
    check("async_rst_data0", ch(0), 0);
    check("async_rst_data1", ch(1), 0);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    impulse_run();
    idle(6);

    t = 0;
    while (q.size() > 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
